// File: rtl/demux_pkg.sv
// Shared channel-count constants and the channel index type for the demux
// word collector.
package demux_pkg;

    localparam int NCH    = 4;
    localparam int ADDR_W = $clog2(NCH);

    typedef logic [ADDR_W-1:0] chan_t;

endpackage

// File: rtl/demux_word_collector_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer
// moves past the winner only when the caller reports the grant was consumed.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;

    // NOTE: every combinational output gets a default before the search loop so no latch is inferred.
    always_comb begin
        logic [IW-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        // Scan from the farthest offset back to ptr so the nearest requester wins.
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + IW'(i);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // NOTE: state is written with non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/demux_word_collector.sv
// Collects bits from the 1-to-4 demux outputs into per-channel words and
// drains completed words round-robin over a valid/ready port.
module demux_word_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_en,
    input  chan_t            addr_i,
    input  logic [NCH-1:0]   dout_i,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output chan_t            out_chan,
    output logic [NCH-1:0]   overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] hold_word [NCH];
    logic [NCH-1:0]   hold_valid;
    logic [NCH-1:0]   drop;
    logic             load_out;
    logic             grant_valid;
    chan_t            grant_idx;
    logic             adv;

    assign load_out = !clear && (!out_valid || out_ready);
    assign adv      = load_out && grant_valid;

    rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (hold_valid),
        .adv         (adv),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [WIDTH-2:0] sreg_q;
        logic [WIDTH-1:0] hold_q;
        logic             hold_v_q;
        logic             hit;
        logic             last;
        logic             take;

        assign hit  = sample_en && (addr_i == ADDR_W'(c));
        assign last = hit && (cnt_q == CNT_W'(WIDTH - 1));
        assign take = adv && (grant_idx == ADDR_W'(c));
        // A word finishing while the slot is still full is lost, unless the
        // slot is being drained to the output on this very edge.
        assign drop[c]       = last && hold_v_q && !take;
        assign hold_word[c]  = hold_q;
        assign hold_valid[c] = hold_v_q;

        // NOTE: the hold registers are reset like any other flop so no stale word can surface after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                sreg_q   <= '0;
                hold_q   <= '0;
                hold_v_q <= 1'b0;
            end else if (clear) begin
                cnt_q    <= '0;
                sreg_q   <= '0;
                hold_q   <= '0;
                hold_v_q <= 1'b0;
            end else begin
                if (hit) begin
                    if (last) begin
                        cnt_q <= '0;
                        if (!drop[c]) begin
                            hold_q <= {dout_i[c], sreg_q};
                        end
                    end else begin
                        sreg_q[cnt_q] <= dout_i[c];
                        cnt_q         <= cnt_q + 1'b1;
                    end
                end
                if (last && !drop[c]) begin
                    hold_v_q <= 1'b1;
                end else if (take) begin
                    hold_v_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_out) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= hold_word[grant_idx];
                out_chan <= grant_idx;
            end
        end
    end

    // Overflow flags stay set until reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= '0;
        end else if (clear) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | drop;
        end
    end

endmodule

// File: tb/tb_demux_word_collector.sv
// Directed and randomized bench for demux_word_collector with a queue/array
// reference model of words, hold slots, output slot and round-robin order.
module tb_demux_word_collector;
    import demux_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             sample_en;
    chan_t            addr_i;
    logic [NCH-1:0]   dout_i;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    chan_t            out_chan;
    logic [NCH-1:0]   overflow;

    int errors = 0;
    int checks = 0;

    demux_word_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .addr_i    (addr_i),
        .dout_i    (dout_i),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: partial words as integer accumulators, one hold slot
    // per channel, one output slot, and a round-robin start channel.
    int               m_cnt [NCH];
    logic [WIDTH-1:0] m_acc [NCH];
    bit               m_hv  [NCH];
    logic [WIDTH-1:0] m_hw  [NCH];
    bit               m_ov;
    logic [WIDTH-1:0] m_od;
    int               m_oc;
    logic [NCH-1:0]   m_ovf;
    int               m_ptr;

    logic [WIDTH+ADDR_W-1:0] acc_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_acc[c] = '0;
            m_hv[c]  = 1'b0;
            m_hw[c]  = '0;
        end
        m_ov  = 1'b0;
        m_od  = '0;
        m_oc  = 0;
        m_ovf = '0;
    endtask

    task automatic model_reset();
        model_clear();
        m_ptr = 0;
    endtask

    task automatic model_step(input bit se, input int ch, input bit b, input bit rdy, input bit clr);
        bit               done;
        logic [WIDTH-1:0] w;
        int               g;
        if (clr) begin
            model_clear();
            return;
        end
        done = 1'b0;
        w    = '0;
        g    = -1;
        if (se) begin
            m_acc[ch] = m_acc[ch] | (WIDTH'(b) << m_cnt[ch]);
            m_cnt[ch]++;
            if (m_cnt[ch] == WIDTH) begin
                w         = m_acc[ch];
                m_acc[ch] = '0;
                m_cnt[ch] = 0;
                done      = 1'b1;
            end
        end
        if (!m_ov || rdy) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_hv[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
            if (g >= 0) begin
                m_ov    = 1'b1;
                m_od    = m_hw[g];
                m_oc    = g;
                m_hv[g] = 1'b0;
                m_ptr   = (g + 1) % NCH;
            end else begin
                m_ov = 1'b0;
            end
        end
        if (done) begin
            if (m_hv[ch]) begin
                m_ovf[ch] = 1'b1;
            end else begin
                m_hw[ch] = w;
                m_hv[ch] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_data", out_data, m_od);
            check("out_chan", out_chan, m_oc);
        end
        check("overflow", overflow, m_ovf);
    endtask

    task automatic cycle(input bit se, input int ch, input bit b, input bit rdy, input bit clr);
        logic [NCH-1:0] d;
        d         = NCH'($urandom);
        d[ch]     = b;
        sample_en = se;
        addr_i    = chan_t'(ch);
        dout_i    = d;
        out_ready = rdy;
        clear     = clr;
        if (out_valid && rdy && !clr) acc_q.push_back({out_chan, out_data});
        model_step(se, ch, b, rdy, clr);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic send_word(input int ch, input logic [WIDTH-1:0] w, input bit rdy);
        for (int i = 0; i < WIDTH; i++) cycle(1'b1, ch, w[i], rdy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sample_en = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [WIDTH-1:0] wa, wb, wc, wd, we, wf, wg;
        logic [WIDTH-1:0] exp_w [NCH];
        logic [7:0]       t2_bits;

        rst_n     = 1'b0;
        sample_en = 1'b0;
        addr_i    = '0;
        dout_i    = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;

        // 1: reset in the middle of random traffic
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, $urandom_range(0, NCH - 1), 1'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        @(negedge clk);
        rst_n     = 1'b0;
        sample_en = 1'b0;
        #1;
        check("t1_async_valid", out_valid, 0);
        check("t1_async_data", out_data, 0);
        check("t1_async_chan", out_chan, 0);
        check("t1_async_ovf", overflow, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: one word on ch2, bits 1,0,1,1,0,0,1,0 (LSB first)
        t2_bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) cycle(1'b1, 2, t2_bits[i], 1'b0, 1'b0);
        check("t2_valid_at_last_bit", out_valid, 0);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t2_valid_next_edge", out_valid, 1);
        check("t2_data", out_data, 8'h4D);
        check("t2_chan", out_chan, 2);

        // 3: interleaved channels 0..3, four words, drained in channel order
        cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        acc_q.delete();
        for (int c = 0; c < NCH; c++) exp_w[c] = '0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            bit b;
            b = 1'($urandom);
            exp_w[i % NCH][i / NCH] = b;
            cycle(1'b1, i % NCH, b, 1'b1, 1'b0);
        end
        repeat (2) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t3_word_count", acc_q.size(), NCH);
        for (int c = 0; c < NCH && c < acc_q.size(); c++) begin
            check("t3_word", acc_q[c], {chan_t'(c), exp_w[c]});
        end

        // 4: backpressure on ch1, third word overflows
        wa = WIDTH'($urandom);
        wb = WIDTH'($urandom);
        wc = WIDTH'($urandom);
        send_word(1, wa, 1'b0);
        send_word(1, wb, 1'b0);
        send_word(1, wc, 1'b0);
        check("t4_overflow", overflow, 4'b0010);
        check("t4_stable_data", out_data, wa);
        check("t4_stable_chan", out_chan, 1);
        acc_q.delete();
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t4_word_count", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            check("t4_first", acc_q[0], {chan_t'(1), wa});
            check("t4_second", acc_q[1], {chan_t'(1), wb});
        end
        check("t4_overflow_sticky", overflow, 4'b0010);

        // 6: clear after a partial word on ch1
        for (int i = 0; i < 5; i++) cycle(1'b1, 1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1, 1'b1, 1'b1, 1'b1);
        check("t6_overflow_cleared", overflow, 0);
        check("t6_valid_cleared", out_valid, 0);
        wd = 8'h12;
        send_word(1, wd, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("t6_clean_data", out_data, 8'h12);
        check("t6_clean_chan", out_chan, 1);

        // 5: ch0 and ch3 pending together with the pointer at 0
        pulse_reset();
        we = WIDTH'($urandom);
        wf = WIDTH'($urandom);
        wg = WIDTH'($urandom);
        send_word(3, we, 1'b0);
        send_word(3, wf, 1'b0);
        send_word(0, wg, 1'b0);
        check("t5_head_chan", out_chan, 3);
        acc_q.delete();
        repeat (4) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("t5_word_count", acc_q.size(), 3);
        if (acc_q.size() >= 3) begin
            check("t5_first", acc_q[0], {chan_t'(3), we});
            check("t5_second", acc_q[1], {chan_t'(0), wg});
            check("t5_third", acc_q[2], {chan_t'(3), wf});
        end

        // Randomized traffic with occasional clear
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, NCH - 1), 1'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
